// File: rtl/tx_phase_sequencer_if.sv
// Control/status bundle between a scan controller and the TX phase sequencer.
// The controller drives table writes, sequence requests and pulse triggers; the sequencer reports phases and status.
interface tx_phase_sequencer_if;
  logic        cfg_we;
  logic [5:0]  cfg_addr;
  logic [4:0]  cfg_data;
  logic [2:0]  n_steps;
  logic [15:0] n_scans;
  logic        start;
  logic        abort;
  logic        pulse_trig;
  logic [1:0]  phase_bin;
  logic        phase_valid;
  logic [2:0]  pulse_idx;
  logic [2:0]  step_idx;
  logic        busy;
  logic        done;
  logic        scan_done;
  logic        code_err;

  modport master (
    output cfg_we, cfg_addr, cfg_data, n_steps, n_scans, start, abort, pulse_trig,
    input  phase_bin, phase_valid, pulse_idx, step_idx, busy, done, scan_done, code_err
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, n_steps, n_scans, start, abort, pulse_trig,
    output phase_bin, phase_valid, pulse_idx, step_idx, busy, done, scan_done, code_err
  );
endinterface

// File: rtl/tx_phase_sequencer.sv
// Steps through a pulse x step table of phase codes, issuing one decoded phase per pulse
// trigger and cycling the step index once per scan until the requested scan count is reached.
module tx_phase_sequencer #(
  parameter int N_PULSES = 3,
  parameter int N_STEPS  = 4
) (
  input logic                 clk,
  input logic                 rst,
  tx_phase_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [3:0] NP         = 4'(N_PULSES);
  localparam logic [3:0] NS         = 4'(N_STEPS);
  localparam logic [2:0] LAST_PULSE = 3'(N_PULSES - 1);

  state_t      state_q, state_d;
  logic [4:0]  table_q [N_STEPS][N_PULSES];
  logic [4:0]  code_rd;
  logic [2:0]  pulse_cnt, step_cnt;
  logic [15:0] scan_cnt, scans_lat;
  logic [3:0]  steps_lat, steps_eff;
  logic        wr_en, start_ok, all_scans, fire, last_pulse;

  logic [1:0]  phase_bin_p1;
  logic        vld_p1;
  logic        scan_done_p1;
  logic [2:0]  pulse_idx_p1, step_idx_p1;
  logic        code_err_q;

  function automatic logic [1:0] decode_phase(input logic [4:0] code);
    case (code)
      5'd9:    return 2'b01;
      5'd18:   return 2'b10;
      5'd27:   return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic illegal_code(input logic [4:0] code);
    case (code)
      5'd0, 5'd9, 5'd18, 5'd27: return 1'b0;
      default:                  return 1'b1;
    endcase
  endfunction

  // A cycle length of 0 means 1; anything deeper than the table clamps to the table depth.
  always_comb begin
    steps_eff = {1'b0, bus.n_steps};
    if (bus.n_steps == 3'd0) steps_eff = 4'd1;
    else if ({1'b0, bus.n_steps} > NS) steps_eff = NS;
  end

  assign start_ok   = (state_q == IDLE) && bus.start;
  assign all_scans  = (scan_cnt == scans_lat);
  assign fire       = (state_q == RUN) && bus.pulse_trig && !bus.abort && !all_scans;
  assign last_pulse = (pulse_cnt == LAST_PULSE);
  assign wr_en      = (state_q == IDLE) && bus.cfg_we &&
                      ({1'b0, bus.cfg_addr[5:3]} < NS) && ({1'b0, bus.cfg_addr[2:0]} < NP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.start) state_d = (bus.n_scans == 16'd0) ? DONE : RUN;
      RUN: begin
        if (bus.abort)     state_d = IDLE;
        else if (all_scans) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < N_STEPS; s++)
        for (int p = 0; p < N_PULSES; p++)
          table_q[s][p] <= 5'd0;
    end else if (wr_en) begin
      for (int s = 0; s < N_STEPS; s++)
        for (int p = 0; p < N_PULSES; p++)
          if (bus.cfg_addr[5:3] == 3'(s) && bus.cfg_addr[2:0] == 3'(p))
            table_q[s][p] <= bus.cfg_data;
    end
  end

  always_comb begin
    code_rd = 5'd0;
    for (int s = 0; s < N_STEPS; s++)
      for (int p = 0; p < N_PULSES; p++)
        if (step_cnt == 3'(s) && pulse_cnt == 3'(p))
          code_rd = table_q[s][p];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pulse_cnt <= 3'd0;
      step_cnt  <= 3'd0;
      scan_cnt  <= 16'd0;
      scans_lat <= 16'd0;
      steps_lat <= 4'd1;
    end else if (start_ok) begin
      pulse_cnt <= 3'd0;
      step_cnt  <= 3'd0;
      scan_cnt  <= 16'd0;
      scans_lat <= bus.n_scans;
      steps_lat <= steps_eff;
    end else if (fire) begin
      if (last_pulse) begin
        pulse_cnt <= 3'd0;
        step_cnt  <= (({1'b0, step_cnt} + 4'd1) >= steps_lat) ? 3'd0 : step_cnt + 3'd1;
        scan_cnt  <= scan_cnt + 16'd1;
      end else begin
        pulse_cnt <= pulse_cnt + 3'd1;
      end
    end
  end

  // p1: phase output stage, one cycle after the accepted trigger
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_bin_p1 <= 2'b00;
      vld_p1       <= 1'b0;
      scan_done_p1 <= 1'b0;
      pulse_idx_p1 <= 3'd0;
      step_idx_p1  <= 3'd0;
      code_err_q   <= 1'b0;
    end else begin
      vld_p1       <= fire;
      scan_done_p1 <= fire && last_pulse;
      if (fire) begin
        phase_bin_p1 <= decode_phase(code_rd);
        pulse_idx_p1 <= pulse_cnt;
        step_idx_p1  <= step_cnt;
      end
      if (start_ok)                          code_err_q <= 1'b0;
      else if (fire && illegal_code(code_rd)) code_err_q <= 1'b1;
    end
  end

  assign bus.phase_bin   = phase_bin_p1;
  assign bus.phase_valid = vld_p1;
  assign bus.scan_done   = scan_done_p1;
  assign bus.pulse_idx   = pulse_idx_p1;
  assign bus.step_idx    = step_idx_p1;
  assign bus.code_err    = code_err_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = (state_q == DONE);

endmodule

// File: doc/tx_phase_sequencer.md
TX_PHASE_SEQUENCER -- requirements
Module: tx_phase_sequencer

Interface
REQ-001 Parameter N_PULSES, default 3, SHALL set the number of TX pulses per scan (legal 1..8).
REQ-002 Parameter N_STEPS, default 4, SHALL set the depth of the phase-cycle table in steps (legal 1..8).
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 cfg_we  input  1  SHALL be the table write strobe.
REQ-006 cfg_addr  input  6  SHALL be the table address: step in [5:3], pulse in [2:0].
REQ-007 cfg_data  input  5  SHALL be the decimal phase code (0=0deg, 9=90deg, 18=180deg, 27=270deg).
REQ-008 n_steps  input  3  SHALL be the active cycle length (0 treated as 1; values above N_STEPS clamp to N_STEPS), sampled at start.
REQ-009 n_scans  input  16  SHALL be the number of scans to run, sampled at start.
REQ-010 start  input  1  SHALL be a single-cycle request to begin a sequence.
REQ-011 abort  input  1  SHALL be a single-cycle request to terminate a sequence.
REQ-012 pulse_trig  input  1  SHALL be a single-cycle request from the pulse generator for the next pulse phase.
REQ-013 phase_bin  output  2  SHALL be the decoded phase for the current pulse (00/01/10/11 = 0/90/180/270 deg).
REQ-014 phase_valid  output  1  SHALL pulse high for one cycle with each new phase_bin.
REQ-015 pulse_idx, step_idx  output  3 each  SHALL report the pulse and step indices of the last issued phase.
REQ-016 busy, done, scan_done, code_err  output  1 each  SHALL flag sequence active, sequence complete (1 cycle), scan complete (1 cycle), and sticky illegal code.

Function
REQ-017 States SHALL be IDLE, RUN, DONE; the table SHALL be N_PULSES x N_STEPS 5-bit registers.
REQ-018 cfg_we in IDLE SHALL write cfg_data to the addressed entry; writes in RUN/DONE or with out-of-range addresses SHALL be ignored.
REQ-019 start in IDLE SHALL latch n_steps/n_scans, clear pulse/step/scan counters, enter RUN, and set busy the next cycle; start outside IDLE SHALL be ignored.
REQ-020 start with n_scans=0 SHALL go directly to DONE without issuing any phase.
REQ-021 pulse_trig in RUN at cycle t SHALL produce phase_valid=1 and phase_bin=decode(table[step][pulse]) at t+1 (latency 1); back-to-back triggers SHALL each be served.
REQ-022 pulse_trig outside RUN SHALL be ignored; phase_bin SHALL hold its last value.
REQ-023 Decode SHALL be 0->00, 9->01, 18->10, 27->11; any other code SHALL output 00 and set code_err until the next start or rst.
REQ-024 After the trigger for pulse N_PULSES-1, pulse index SHALL wrap to 0, scan_done SHALL pulse with the phase output, step SHALL advance modulo the latched n_steps, and scan count SHALL increment.
REQ-025 When scan count reaches the latched n_scans, the FSM SHALL enter DONE; done SHALL be high for exactly one cycle; busy SHALL then drop and the FSM SHALL return to IDLE.
REQ-026 abort in RUN SHALL return to IDLE next cycle without done or scan_done, with busy low; abort SHALL win over a simultaneous pulse_trig.
REQ-027 Step count SHALL be 3-bit and scan count 16-bit with no overflow beyond n_scans.

Reset
REQ-028 rst SHALL immediately force IDLE, clear table to 0, and drive phase_bin=00, phase_valid=0, pulse_idx=0, step_idx=0, busy=0, done=0, scan_done=0, code_err=0.
REQ-029 rst asserted during RUN SHALL abandon the sequence with no done pulse.

Verification
REQ-030 Load step0={0,9,18}, step1={9,18,27}, n_steps=2, n_scans=2, start, 6 triggers -> phase_bin 00,01,10 then 01,10,11; scan_done on 3rd and 6th; done one cycle after 6th output.
REQ-031 n_steps=2, n_scans=5, N_PULSES=3 -> step_idx sequence 0,1,0,1,0 per scan; exactly 15 phase_valid pulses.
REQ-032 Table entry 5 at step0 pulse1 -> phase_bin 00 on that pulse, code_err high and held until next start.
REQ-033 abort coincident with 2nd trigger -> no phase_valid for it, busy low next cycle, no done; new start restarts at pulse 0 step 0.
REQ-034 start with n_scans=0 -> done one cycle, zero phase_valid; cfg_we and start during RUN -> table and counters unchanged.
REQ-035 rst mid-RUN -> all outputs at reset values immediately; table reads back 0 (all subsequent phases 00).
